mcs4_ram_chip: RTL and testbench

Cycle-accurate model of one MCS-4 data RAM chip (4002 style) attached to the CPU's shared 4-bit bus. It tracks the 8-phase instruction cycle from `sync_i` and decodes SRC addressing and I/O-RAM commands using the bank's CM-RAM line. It holds 4 registers × (16 main + 4 status) characters plus a 4-bit output port. It is the downstream consumer of the CPU's bus traffic; one instance exists per chip position, with up to 4 per bank.

---
 rtl/mcs4_pkg.sv | 68 ++++++
 rtl/mcs4_cycle_tracker.sv | 49 ++++
 rtl/mcs4_ram_chip.sv | 151 +++++++++++++++
 tb/tb_mcs4_ram_chip.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 types, I/O-RAM opcodes and RAM chip sizing.
// Latency: n/a (declarations and combinational helper functions only).
// Backpressure: n/a.
package mcs4_pkg;

  // One bus character (4 bits).
  typedef logic [3:0] char_t;

  // RAM addressing fields carried by the two SRC nibbles.
  typedef logic [1:0] ram_chip_sel_t;   // SRC high nibble [3:2]
  typedef logic [1:0] ram_reg_sel_t;    // SRC high nibble [1:0]
  typedef logic [3:0] ram_char_sel_t;   // SRC low nibble
  typedef logic [1:0] ram_schar_sel_t;  // status character, from the opcode

  // Eight machine phases per instruction, plus IDLE before the first sync.
  typedef enum logic [3:0] {
    CYC_IDLE = 4'd0,
    CYC_A1   = 4'd1,
    CYC_A2   = 4'd2,
    CYC_A3   = 4'd3,
    CYC_M1   = 4'd4,
    CYC_M2   = 4'd5,
    CYC_X1   = 4'd6,
    CYC_X2   = 4'd7,
    CYC_X3   = 4'd8
  } instr_cyc_t;

  // Storage per chip: 4 registers x 16 main characters, 4 x 4 status characters.
  localparam int Ram_words_per_chip        = 64;
  localparam int Ram_status_words_per_chip = 16;

  // I/O-RAM command OPA values (OPR = 4'hE).
  localparam char_t OPA_WRM = 4'h0;
  localparam char_t OPA_WMP = 4'h1;
  localparam char_t OPA_WRR = 4'h2;
  localparam char_t OPA_UND = 4'h3;
  localparam char_t OPA_WR0 = 4'h4;
  localparam char_t OPA_WR1 = 4'h5;
  localparam char_t OPA_WR2 = 4'h6;
  localparam char_t OPA_WR3 = 4'h7;
  localparam char_t OPA_SBM = 4'h8;
  localparam char_t OPA_RDM = 4'h9;
  localparam char_t OPA_RDR = 4'hA;
  localparam char_t OPA_ADM = 4'hB;
  localparam char_t OPA_RD0 = 4'hC;
  localparam char_t OPA_RD1 = 4'hD;
  localparam char_t OPA_RD2 = 4'hE;
  localparam char_t OPA_RD3 = 4'hF;

  // Commands for which the RAM chip drives the bus in X2.
  function automatic logic is_ram_read(char_t opa);
    case (opa)
      OPA_SBM, OPA_RDM, OPA_ADM,
      OPA_RD0, OPA_RD1, OPA_RD2, OPA_RD3: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Commands for which the RAM chip captures the bus in X2.
  function automatic logic is_ram_write(char_t opa);
    case (opa)
      OPA_WRM, OPA_WMP,
      OPA_WR0, OPA_WR1, OPA_WR2, OPA_WR3: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcs4_cycle_tracker.sv
// Machine-phase tracker: IDLE until sync, then A1..X3 repeating; sync forces A1.
// Latency: phase_o is registered; sync_i seen on an edge gives A1 for the following clock.
// Backpressure: none; free-running once synced.
//
// Ports:
//   clk     in   machine phase clock
//   rst     in   async active-high reset -> IDLE
//   sync_i  in   high during X3 (or any phase, to resync)
//   phase_o out  current phase
module mcs4_cycle_tracker
  import mcs4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_i,
  output instr_cyc_t phase_o
);

  instr_cyc_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CYC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sync_i) begin
      // Resync from any state, including IDLE and mid-instruction phases.
      state_d = CYC_A1;
    end else begin
      case (state_q)
        CYC_IDLE: state_d = CYC_IDLE;
        CYC_A1:   state_d = CYC_A2;
        CYC_A2:   state_d = CYC_A3;
        CYC_A3:   state_d = CYC_M1;
        CYC_M1:   state_d = CYC_M2;
        CYC_M2:   state_d = CYC_X1;
        CYC_X1:   state_d = CYC_X2;
        CYC_X2:   state_d = CYC_X3;
        CYC_X3:   state_d = CYC_A1;
        default:  state_d = CYC_IDLE;
      endcase
    end
  end

  assign phase_o = state_q;

endmodule

// File: rtl/mcs4_ram_chip.sv
// One 4002-style data RAM chip on the MCS-4 bus: SRC decode, I/O-RAM commands, 4-bit output port.
// Latency: reads drive the bus combinationally during X2; writes commit on the edge ending X2.
// Backpressure: none; the chip follows the CPU bus timing and cannot stall it.
//
// Ports:
//   clk        in   machine phase clock
//   rst        in   async active-high reset
//   sync_i     in   X3 marker from the CPU
//   cm_ram_i   in   this bank's CM-RAM line
//   data_i     in   CPU-driven bus nibble
//   data_o     out  chip-driven bus nibble (0 when not driving)
//   data_oe    out  bus drive enable (X2 of a selected read only)
//   out_port_o out  output port register, loaded by WMP
module mcs4_ram_chip
  import mcs4_pkg::*;
#(
  parameter ram_chip_sel_t CHIP_ID = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_i,
  input  logic       cm_ram_i,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_oe,
  output logic [3:0] out_port_o
);

  instr_cyc_t phase;

  mcs4_cycle_tracker u_tracker (
    .clk     (clk),
    .rst     (rst),
    .sync_i  (sync_i),
    .phase_o (phase)
  );

  // Control state.
  char_t         cmd_opa_q,   cmd_opa_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          selected_q,  selected_d;
  ram_reg_sel_t  reg_sel_q,   reg_sel_d;
  ram_char_sel_t char_sel_q,  char_sel_d;
  logic          src_lo_q,    src_lo_d;
  char_t         out_port_q,  out_port_d;

  // Storage.
  char_t main_q [Ram_words_per_chip];
  char_t stat_q [Ram_status_words_per_chip];

  logic [5:0] main_idx;
  logic [3:0] stat_idx;
  logic       mid_sync;
  logic       exec_wr;
  logic       main_we;
  logic       stat_we;
  logic       rd_en;

  assign main_idx = {reg_sel_q, char_sel_q};
  assign stat_idx = {reg_sel_q, ram_schar_sel_t'(cmd_opa_q[1:0])};

  // A sync outside X3 means the CPU restarted the instruction: anything
  // half-decoded in this instruction is dropped and no phase action runs.
  assign mid_sync = sync_i && (phase != CYC_X3);

  // Writes only for a latched command addressed to this chip.
  assign exec_wr = !mid_sync && (phase == CYC_X2) && cmd_valid_q && selected_q &&
                   is_ram_write(cmd_opa_q);
  assign main_we = exec_wr && (cmd_opa_q == OPA_WRM);
  assign stat_we = exec_wr && (cmd_opa_q[3:2] == 2'b01);

  always_comb begin
    cmd_opa_d   = cmd_opa_q;
    cmd_valid_d = cmd_valid_q;
    selected_d  = selected_q;
    reg_sel_d   = reg_sel_q;
    char_sel_d  = char_sel_q;
    src_lo_d    = src_lo_q;
    out_port_d  = out_port_q;

    if (mid_sync) begin
      cmd_valid_d = 1'b0;
      src_lo_d    = 1'b0;
    end else begin
      case (phase)
        CYC_A1: cmd_valid_d = 1'b0;
        CYC_M2: begin
          // CM-RAM in M2 marks an I/O-RAM instruction; OPA is on the bus.
          cmd_valid_d = cm_ram_i;
          if (cm_ram_i) cmd_opa_d = data_i;
        end
        CYC_X2: begin
          if (cm_ram_i && !cmd_valid_q) begin
            // SRC high nibble: chip number and register select.
            selected_d = (data_i[3:2] == CHIP_ID);
            reg_sel_d  = data_i[1:0];
            src_lo_d   = 1'b1;
          end
          if (exec_wr && (cmd_opa_q == OPA_WMP)) out_port_d = data_i;
        end
        CYC_X3: begin
          if (src_lo_q) char_sel_d = data_i;
          src_lo_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_opa_q   <= '0;
      cmd_valid_q <= 1'b0;
      selected_q  <= 1'b0;
      reg_sel_q   <= '0;
      char_sel_q  <= '0;
      src_lo_q    <= 1'b0;
      out_port_q  <= '0;
    end else begin
      cmd_opa_q   <= cmd_opa_d;
      cmd_valid_q <= cmd_valid_d;
      selected_q  <= selected_d;
      reg_sel_q   <= reg_sel_d;
      char_sel_q  <= char_sel_d;
      src_lo_q    <= src_lo_d;
      out_port_q  <= out_port_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Ram_words_per_chip; i++) main_q[i] <= '0;
      for (int i = 0; i < Ram_status_words_per_chip; i++) stat_q[i] <= '0;
    end else begin
      if (main_we) main_q[main_idx] <= data_i;
      if (stat_we) stat_q[stat_idx] <= data_i;
    end
  end

  // Read path: SBM/RDM/ADM have opa[2]=0 (main), RD0-RD3 have opa[2]=1 (status).
  assign rd_en = (phase == CYC_X2) && cmd_valid_q && selected_q && is_ram_read(cmd_opa_q);

  always_comb begin
    data_o = '0;
    if (rd_en) data_o = cmd_opa_q[2] ? stat_q[stat_idx] : main_q[main_idx];
  end

  assign data_oe    = rd_en;
  assign out_port_o = out_port_q;

endmodule

// File: tb/tb_mcs4_ram_chip.sv
module tb_mcs4_ram_chip;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_i = 1'b0;
  logic       cm_ram_i = 1'b0;
  logic [3:0] data_i = 4'h0;
  logic [3:0] data_o;
  logic       data_oe;
  logic [3:0] out_port_o;

  mcs4_ram_chip #(.CHIP_ID(2'd2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_i     (sync_i),
    .cm_ram_i   (cm_ram_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .data_oe    (data_oe),
    .out_port_o (out_port_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       oe;
    logic [3:0] d;
    logic [3:0] port;
  } exp_t;
  exp_t sb[$];

  // Reference model of the chip as seen from the bus.
  logic       m_sel = 1'b0;
  logic [1:0] m_reg = 2'd0;
  logic [3:0] m_char = 4'h0;
  logic       m_cv = 1'b0;
  logic [3:0] m_opa = 4'h0;
  logic       m_srclo = 1'b0;
  logic [3:0] m_port = 4'h0;
  logic [3:0] m_main [64];
  logic [3:0] m_stat [16];

  // DUT bus values seen in X2 of the latest instruction.
  logic       x2_oe;
  logic [3:0] x2_do;

  function automatic logic model_reads(input logic [3:0] opa);
    return (opa == 4'h8) || (opa == 4'h9) || (opa == 4'hB) || (opa[3:2] == 2'b11);
  endfunction

  task automatic model_reset();
    m_sel = 0; m_reg = 0; m_char = 0; m_cv = 0; m_opa = 0; m_srclo = 0; m_port = 0;
    for (int i = 0; i < 64; i++) m_main[i] = 4'h0;
    for (int i = 0; i < 16; i++) m_stat[i] = 4'h0;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One machine phase: drive after the edge, compare the queued expectation mid-phase.
  task automatic phase(input logic s, input logic cm, input logic [3:0] d,
                       input logic eoe, input logic [3:0] ed, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    sync_i = s; cm_ram_i = cm; data_i = d;
    e.oe = eoe; e.d = ed; e.port = m_port;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_oe"}, {3'b0, data_oe}, {3'b0, e.oe});
    chk({tag, "_do"}, data_o, e.d);
    chk({tag, "_port"}, out_port_o, e.port);
  endtask

  // A full 8-phase instruction A1..X3 with sync in X3.
  task automatic instr(input string tag, input logic cm_m2, input logic [3:0] d_m2,
                       input logic cm_x2, input logic [3:0] d_x2, input logic [3:0] d_x3);
    for (int i = 0; i < 8; i++) begin
      logic       cm;
      logic [3:0] d;
      logic       eoe;
      logic [3:0] ed;
      cm = 0; d = 0; eoe = 0; ed = 0;
      if (i == 0) m_cv = 0;
      if (i == 4) begin cm = cm_m2; d = d_m2; end
      if (i == 6) begin
        cm = cm_x2; d = d_x2;
        if (m_cv && m_sel && model_reads(m_opa)) begin
          eoe = 1;
          ed  = m_opa[2] ? m_stat[{m_reg, m_opa[1:0]}] : m_main[{m_reg, m_char}];
        end
      end
      if (i == 7) d = d_x3;
      phase(i == 7, cm, d, eoe, ed, tag);
      if (i == 6) begin
        x2_oe = data_oe; x2_do = data_o;
      end
      if (i == 4) begin m_cv = cm_m2; if (cm_m2) m_opa = d_m2; end
      if (i == 6) begin
        if (cm_x2 && !m_cv) begin
          m_sel = (d_x2[3:2] == 2'd2); m_reg = d_x2[1:0]; m_srclo = 1;
        end else if (m_cv && m_sel) begin
          if (m_opa == 4'h0) m_main[{m_reg, m_char}] = d_x2;
          if (m_opa == 4'h1) m_port = d_x2;
          if (m_opa[3:2] == 2'b01) m_stat[{m_reg, m_opa[1:0]}] = d_x2;
        end
      end
      if (i == 7 && m_srclo) begin m_char = d_x3; m_srclo = 0; end
    end
  endtask

  initial begin
    model_reset();
    // Reset state.
    phase(0, 0, 4'h0, 0, 4'h0, "reset");
    phase(0, 0, 4'h0, 0, 4'h0, "reset");
    @(negedge clk); rst = 0;
    // Tracker idles without sync even with bus activity.
    phase(0, 1, 4'h9, 0, 4'h0, "idle");
    phase(0, 1, 4'h9, 0, 4'h0, "idle");
    phase(1, 0, 4'h0, 0, 4'h0, "sync");

    // Select chip 2, reg 1, char 5; WRM A; RDM.
    instr("src_c2", 0, 4'h0, 1, 4'b1001, 4'h5);
    instr("wrm_a", 1, 4'h0, 0, 4'hA, 4'h0);
    instr("rdm_a", 1, 4'h9, 0, 4'h0, 4'h0);
    chk("rdm_a_val", x2_do, 4'hA);
    chk("rdm_a_oe", {3'b0, x2_oe}, 4'h1);

    // Status characters.
    instr("wr2_7", 1, 4'h6, 0, 4'h7, 4'h0);
    instr("rd2", 1, 4'hE, 0, 4'h0, 4'h0);
    chk("rd2_val", x2_do, 4'h7);
    instr("rd1", 1, 4'hD, 0, 4'h0, 4'h0);
    chk("rd1_val", x2_do, 4'h0);
    chk("rd1_oe", {3'b0, x2_oe}, 4'h1);
    instr("rdm_a2", 1, 4'h9, 0, 4'h0, 4'h0);
    chk("rdm_a2_val", x2_do, 4'hA);

    // Output port, then RDR/WRR leave it alone and never drive.
    instr("wmp_3", 1, 4'h1, 0, 4'h3, 4'h0);
    chk("wmp_port", out_port_o, 4'h3);
    instr("rdr", 1, 4'hA, 0, 4'h0, 4'h0);
    chk("rdr_oe", {3'b0, x2_oe}, 4'h0);
    instr("wrr", 1, 4'h2, 0, 4'hC, 4'h0);
    chk("wrr_oe", {3'b0, x2_oe}, 4'h0);
    chk("wrr_port", out_port_o, 4'h3);

    // Another chip selected: silent and no write.
    instr("src_c1", 0, 4'h0, 1, 4'b0100, 4'h5);
    instr("rdm_c1", 1, 4'h9, 0, 4'h0, 4'h0);
    chk("rdm_c1_oe", {3'b0, x2_oe}, 4'h0);
    chk("rdm_c1_do", x2_do, 4'h0);
    instr("wrm_c1", 1, 4'h0, 0, 4'hF, 4'h0);
    instr("src_c2b", 0, 4'h0, 1, 4'b1001, 4'h5);
    instr("rdm_c2b", 1, 4'h9, 0, 4'h0, 4'h0);
    chk("rdm_c2b_val", x2_do, 4'hA);

    // SRC without CM-RAM leaves the selection untouched.
    instr("src_nocm", 0, 4'h0, 0, 4'b0100, 4'h0);
    instr("rdm_nocm", 1, 4'h9, 0, 4'h0, 4'h0);
    chk("rdm_nocm_val", x2_do, 4'hA);
    chk("rdm_nocm_oe", {3'b0, x2_oe}, 4'h1);

    // Reset during M2 of a WRM.
    phase(0, 0, 4'h0, 0, 4'h0, "pre_rst");
    phase(0, 0, 4'h0, 0, 4'h0, "pre_rst");
    phase(0, 0, 4'h0, 0, 4'h0, "pre_rst");
    phase(0, 0, 4'h0, 0, 4'h0, "pre_rst");
    @(posedge clk);
    #1;
    cm_ram_i = 1; data_i = 4'h0;
    #1 rst = 1;
    model_reset();
    @(negedge clk);
    chk("rst_oe", {3'b0, data_oe}, 4'h0);
    chk("rst_do", data_o, 4'h0);
    chk("rst_port", out_port_o, 4'h0);
    #2 rst = 0;
    // Remaining phases of the aborted WRM, then silence until sync.
    phase(0, 0, 4'h0, 0, 4'h0, "post_rst");
    phase(0, 0, 4'hF, 0, 4'h0, "post_rst");
    phase(0, 1, 4'h9, 0, 4'h0, "post_rst");
    phase(0, 1, 4'h9, 0, 4'h0, "post_rst");
    phase(1, 0, 4'h0, 0, 4'h0, "resync");
    instr("src_rst", 0, 4'h0, 1, 4'b1001, 4'h5);
    // Sync in M1 restarts the instruction at A1.
    phase(0, 0, 4'h0, 0, 4'h0, "m1sync");
    phase(0, 0, 4'h0, 0, 4'h0, "m1sync");
    phase(0, 0, 4'h0, 0, 4'h0, "m1sync");
    phase(1, 0, 4'h0, 0, 4'h0, "m1sync");
    instr("rdm_after", 1, 4'h9, 0, 4'h0, 4'h0);
    chk("rdm_after_oe", {3'b0, x2_oe}, 4'h1);
    chk("rdm_after_val", x2_do, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
